// File: rtl/mispredict_arbiter_seq_if.sv
// rtl/mispredict_arbiter_seq_if.sv - branch writeback inputs and recovery fire outputs of the mispredict arbiter
// master drives the branch units and ROB head; slave is the arbiter.
interface mispredict_arbiter_seq_if #(
   parameter int ROB_DEPTH = 16,
   parameter int NUM_BR    = 2
);
   localparam int TAG_W = $clog2(ROB_DEPTH);

   logic [NUM_BR-1:0]       br_valid_i;
   logic [NUM_BR-1:0]       br_mispredict_i;
   logic [NUM_BR*TAG_W-1:0] br_rob_tag_i;
   logic [NUM_BR*32-1:0]    br_target_i;
   logic [TAG_W-1:0]        rob_head_i;
   logic                    fire_o;
   logic [TAG_W-1:0]        fire_rob_tag_o;
   logic [31:0]             fire_target_o;
   logic                    busy_o;
   logic                    preempt_o;

   modport master (
      output br_valid_i, br_mispredict_i, br_rob_tag_i, br_target_i, rob_head_i,
      input  fire_o, fire_rob_tag_o, fire_target_o, busy_o, preempt_o
   );

   modport slave (
      input  br_valid_i, br_mispredict_i, br_rob_tag_i, br_target_i, rob_head_i,
      output fire_o, fire_rob_tag_o, fire_target_o, busy_o, preempt_o
   );
endinterface

// File: rtl/mispredict_arbiter_seq.sv
// rtl/mispredict_arbiter_seq.sv - picks the oldest mispredict vs ROB head, fires recovery, holds a drain window
// Optional counters stat_fires_o/stat_preempts_o/stat_drops_o under `define MISP_ARB_STATS_EN.
module mispredict_arbiter_seq #(
   parameter int ROB_DEPTH    = 16,
   parameter int NUM_BR       = 2,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   mispredict_arbiter_seq_if.slave br
`ifdef MISP_ARB_STATS_EN
   ,
   output logic [31:0]            stat_fires_o,
   output logic [31:0]            stat_preempts_o,
   output logic [31:0]            stat_drops_o
`endif
);
   localparam int         TAG_W      = $clog2(ROB_DEPTH);
   localparam logic [3:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 4'(DRAIN_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECOVER = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [TAG_W-1:0]  lat_tag_q, lat_tag_d;
   logic [31:0]       lat_target_q, lat_target_d;
   logic              preempt_q, preempt_d;

   logic [NUM_BR-1:0] cand;
   logic              win_valid;
   logic [TAG_W-1:0]  win_tag;
   logic [TAG_W-1:0]  win_age;
   logic [31:0]       win_target;
   logic [TAG_W-1:0]  lat_age;
   logic              older;

   // Age is modular distance from the head; strict < keeps the lowest port on ties.
   always_comb begin
      cand       = br.br_valid_i & br.br_mispredict_i;
      win_valid  = 1'b0;
      win_tag    = '0;
      win_age    = '0;
      win_target = '0;
      for (int k = 0; k < NUM_BR; k++) begin
         if (cand[k] && (!win_valid ||
             (br.br_rob_tag_i[k*TAG_W +: TAG_W] - br.rob_head_i) < win_age)) begin
            win_valid  = 1'b1;
            win_tag    = br.br_rob_tag_i[k*TAG_W +: TAG_W];
            win_age    = br.br_rob_tag_i[k*TAG_W +: TAG_W] - br.rob_head_i;
            win_target = br.br_target_i[k*32 +: 32];
         end
      end
      lat_age = lat_tag_q - br.rob_head_i;
      older   = win_valid && (win_age < lat_age);
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      lat_tag_d    = lat_tag_q;
      lat_target_d = lat_target_q;
      preempt_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               lat_tag_d    = win_tag;
               lat_target_d = win_target;
               state_d      = RECOVER;
            end
         end
         RECOVER: begin
            if (older) begin
               lat_tag_d    = win_tag;
               lat_target_d = win_target;
               preempt_d    = 1'b1;
            end else if (DRAIN_CYCLES == 0) begin
               state_d = IDLE;
            end else begin
               state_d = DRAIN;
               cnt_d   = DRAIN_LOAD;
            end
         end
         DRAIN: begin
            if (older) begin
               lat_tag_d    = win_tag;
               lat_target_d = win_target;
               preempt_d    = 1'b1;
               state_d      = RECOVER;
            end else if (cnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         lat_tag_q    <= '0;
         lat_target_q <= '0;
         preempt_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lat_tag_q    <= lat_tag_d;
         lat_target_q <= lat_target_d;
         preempt_q    <= preempt_d;
      end
   end

   assign br.fire_o         = (state_q == RECOVER);
   assign br.busy_o         = (state_q != IDLE);
   assign br.preempt_o      = preempt_q;
   assign br.fire_rob_tag_o = lat_tag_q;
   assign br.fire_target_o  = lat_target_q;

`ifdef MISP_ARB_STATS_EN
   logic [31:0] n_cand;
   logic [31:0] n_drop;
   logic        accepted;
   logic [32:0] drop_sum;

   // Every candidate except the one that gets latched this cycle is a drop.
   always_comb begin
      n_cand = '0;
      for (int k = 0; k < NUM_BR; k++) begin
         n_cand = n_cand + 32'(cand[k]);
      end
      accepted = (state_q == IDLE) ? win_valid : older;
      n_drop   = n_cand - 32'(accepted);
      drop_sum = {1'b0, stat_drops_o} + {1'b0, n_drop};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stat_fires_o    <= '0;
         stat_preempts_o <= '0;
         stat_drops_o    <= '0;
      end else begin
         if (br.fire_o && (stat_fires_o != '1)) begin
            stat_fires_o <= stat_fires_o + 32'd1;
         end
         if (preempt_q && (stat_preempts_o != '1)) begin
            stat_preempts_o <= stat_preempts_o + 32'd1;
         end
         stat_drops_o <= drop_sum[32] ? '1 : drop_sum[31:0];
      end
   end
`endif
endmodule

// File: doc/mispredict_arbiter_seq.md
Name: mispredict_arbiter_seq

Overview:
- Arbitrates mispredict writebacks from NUM_BR branch units and selects the oldest relative to the ROB head.
- Issues a single-cycle recovery fire to the recovery controller, then holds a busy window of DRAIN_CYCLES for the frontend and dispatch stall.
- Sits between the branch-unit writeback buses and the recovery controller's branch input.
- While recovery is in flight, a strictly older mispredict preempts the current one; younger or equal-age ones are dropped.

Parameters:
ROB_DEPTH, 16, ROB entries; TAG_W = $clog2(ROB_DEPTH)
NUM_BR, 2, number of branch writeback ports
DRAIN_CYCLES, 2, busy cycles after fire before returning to idle; legal range 0..15

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
br_valid_i  in  NUM_BR  per-port writeback valid
br_mispredict_i  in  NUM_BR  per-port mispredict flag
br_rob_tag_i  in  NUM_BR*TAG_W  per-port ROB tag; port k occupies bits [k*TAG_W +: TAG_W]
br_target_i  in  NUM_BR*32  per-port corrected PC; port k occupies bits [k*32 +: 32]
rob_head_i  in  TAG_W  current ROB head index
fire_o  out  1  one-cycle recovery request to the recovery controller
fire_rob_tag_o  out  TAG_W  ROB tag of the selected branch
fire_target_o  out  32  redirect PC of the selected branch
busy_o  out  1  high while state != IDLE
preempt_o  out  1  one-cycle pulse; high when the current fire replaced an in-flight recovery

Behaviour:
- Reset: state=IDLE, counter=0, all outputs 0, latched tag and target 0. Reset mid-recovery aborts immediately; no pending fire survives.
- Candidate: port k with br_valid_i[k] & br_mispredict_i[k].
- Age: age(t) = (t - rob_head_i) mod ROB_DEPTH, computed at TAG_W bits with natural wrap. Smaller age is older.
- Ties (equal age): lowest port index wins.
- Winner: the oldest candidate among all ports in the current cycle. All arithmetic is combinational.
- The age of the latched tag is recomputed every cycle against the current rob_head_i, because the head may advance while recovery is in flight.
- States:
  - IDLE:
    - If any candidate exists: latch the winner's tag and target; next state RECOVER.
    - Otherwise stay in IDLE.
  - RECOVER:
    - fire_o=1 for exactly this cycle; fire_rob_tag_o and fire_target_o show the latched values.
    - If a winner exists with age < age(latched): latch it, stay in RECOVER (a new fire next cycle), preempt_o=1 on that next fire.
    - Else if DRAIN_CYCLES=0: go to IDLE.
    - Else: go to DRAIN with counter=DRAIN_CYCLES-1.
  - DRAIN:
    - If a winner exists with age < age(latched): latch it, go to RECOVER, preempt_o=1 on the resulting fire.
    - Else if counter=0: go to IDLE.
    - Else: counter-1.
- Candidates not older than the latched tag in RECOVER or DRAIN are dropped silently; they are squashed by the in-flight flush.
- Latency: a candidate in IDLE at cycle N produces fire_o in cycle N+1.
- busy_o is registered and equals (state != IDLE). It is high from the first RECOVER cycle through the last DRAIN cycle.
- fire_rob_tag_o and fire_target_o hold their last values when fire_o=0.
- A candidate arriving in the same cycle the FSM returns DRAIN->IDLE is dropped only if it is not older. An older one preempts per the DRAIN rule.
- A candidate presented in the first IDLE cycle after DRAIN is accepted normally.
- Non-mispredict writebacks (br_mispredict_i=0) are ignored in every state.

Optional Feature:
MISP_ARB_STATS_EN
- When defined, adds three outputs:
  - stat_fires_o (32): increments on each fire_o cycle.
  - stat_preempts_o (32): increments on each preempt_o cycle.
  - stat_drops_o (32): increments by the number of candidates dropped in that cycle.
- Each counter saturates at all-ones and resets to 0.
- When not defined: these ports and counters do not exist, and there is no functional change to the other outputs.

Test Plan:
- Single mispredict: rob_head=0, port0 tag=5, target=0x1000 in IDLE. Required: fire_o next cycle with tag 5, target 0x1000; busy_o high for 1+2 cycles; then IDLE.
- Two same-cycle candidates: head=14, port0 tag=2 (age 4), port1 tag=15 (age 1). Required: fire with tag 15; tag 2 dropped; no second fire.
- Preempt in DRAIN: latched tag 9 with head=4; in DRAIN, port1 tag=6 arrives. Required: fire tag 6 next cycle with preempt_o=1, counter reloaded, busy_o stays high continuously.
- Younger in DRAIN: latched tag 6 with head=4; tag 9 arrives. Required: no fire, state unchanged, drop counted when MISP_ARB_STATS_EN is defined.
- Head wrap: head=15, candidate tag=0 (age 1) vs tag=14 (age 15). Required: tag 0 selected.
- Reset during DRAIN. Required: all outputs 0 immediately. A mispredict presented the cycle after release fires one cycle later.
